// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: shared state encoding and default sizes for the triangle sweep sequencer.
package updown_sweep_pkg;
   localparam int DEF_WIDTH  = 4;
   localparam int DEF_REPS_W = 4;
   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_e;
endpackage

// File: rtl/updown_sweep_ctrl_counter.sv
// sweep_step_counter: loadable up/down counter stepped one unit per enabled cycle.
module sweep_step_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   logic [WIDTH-1:0] count_q, count_d;
   always_comb count_d = load ? load_val : en ? (up ? count_q + ONE : count_q - ONE) : count_q;
   always_ff @(posedge clk)
      count_q <= reset ? '0 : count_d;
   assign count = count_q;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: repeats lo->hi->lo triangle sweeps with start/busy/done, pause and abort.
// Defining UPDOWN_SWEEP_ERR_EN adds an err pulse for starts with an illegal configuration.
module updown_sweep_ctrl
   import updown_sweep_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int REPS_W = DEF_REPS_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [REPS_W-1:0] reps,
   input  logic              pause,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              up,
   output logic              busy,
   output logic              done,
   output logic [REPS_W-1:0] reps_done
`ifdef UPDOWN_SWEEP_ERR_EN
   ,
   output logic              err
`endif
);
   localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
   localparam logic [REPS_W-1:0] ONE_R = REPS_W'(1);
   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lo_q, hi_q;
   logic [REPS_W-1:0] reps_q, reps_done_q, reps_done_d, reps_nxt;
   logic              done_q, load, en, legal;
   assign legal    = (lo < hi) && (reps != '0);
   assign reps_nxt = reps_done_q + ONE_R;
   // The counter only moves by one per step and turns at the bounds, so it never wraps.
   always_comb begin
      state_d     = state_q;
      reps_done_d = reps_done_q;
      load        = 1'b0;
      en          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && legal) begin
               load        = 1'b1;
               reps_done_d = '0;
               state_d     = S_UP;
            end
         end
         S_UP: begin
            if (abort) state_d = S_IDLE;
            else if (!pause) begin
               en = 1'b1;
               if (count == hi_q - ONE) state_d = S_DOWN;
            end
         end
         S_DOWN: begin
            if (abort) state_d = S_IDLE;
            else if (!pause) begin
               en = 1'b1;
               if (count == lo_q + ONE) begin
                  reps_done_d = reps_nxt;
                  state_d     = (reps_nxt == reps_q) ? S_DONE : S_UP;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         reps_done_q <= '0;
         done_q      <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
         reps_q      <= '0;
      end else begin
         state_q     <= state_d;
         reps_done_q <= reps_done_d;
         done_q      <= state_d == S_DONE;
         if (load) begin
            lo_q   <= lo;
            hi_q   <= hi;
            reps_q <= reps;
         end
      end
   end
`ifdef UPDOWN_SWEEP_ERR_EN
   logic err_q;
   always_ff @(posedge clk)
      err_q <= reset ? 1'b0 : (state_q == S_IDLE) && start && !legal;
   assign err = err_q;
`endif
   sweep_step_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .load_val(lo),
      .en      (en),
      .up      (state_q == S_UP),
      .count   (count)
   );
   assign up        = state_q == S_UP;
   assign busy      = (state_q == S_UP) || (state_q == S_DOWN);
   assign done      = done_q;
   assign reps_done = reps_done_q;
endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer that drives a loadable up/down counter through programmed triangle sweeps. Each sweep runs lo→hi→lo, and the block repeats it `reps` times. It uses a start/busy/done handshake and supports pause and abort. It sits between a control register block and counter-consuming logic (PWM ramps, address sweeps), and supplies both the count value and the current direction.

Parameters:
- WIDTH, 4, counter width in bits.
- REPS_W, 4, width of the repetition count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- lo  in  WIDTH  lower sweep bound; latched at start.
- hi  in  WIDTH  upper sweep bound; latched at start.
- reps  in  REPS_W  number of full sweeps; latched at start.
- pause  in  1  while 1, count and state are frozen.
- abort  in  1  return to IDLE without a done pulse.
- count  out  WIDTH  current counter value.
- up  out  1  1 while in UP state, else 0.
- busy  out  1  1 in UP or DOWN state.
- done  out  1  one-cycle pulse at completion.
- reps_done  out  REPS_W  number of completed sweeps.

Behaviour:
- Reset values: state=IDLE, count=0, up=0, busy=0, done=0, reps_done=0, err=0. Reset has priority over every other input and may be applied mid-sweep.
- States: IDLE, UP, DOWN, DONE.
- Legal configuration: lo<hi and reps!=0.
- IDLE + start + legal config, at edge E0: latch lo/hi/reps; count<=lo; reps_done<=0; state<=UP.
- IDLE + start + illegal config: handled per the optional feature.
- UP, active cycle (pause=0):
  - if count==hi-1: count<=hi, state<=DOWN;
  - else count<=count+1.
- DOWN, active cycle:
  - if count==lo+1: count<=lo, reps_done<=reps_done+1; then state<=DONE if reps_done+1==reps, else state<=UP;
  - else count<=count-1.
- DONE: done=1 for exactly one cycle, busy=0, count holds lo; next state IDLE.
- Latency: done is high in the cycle after edge E0+2*(hi-lo)*reps, plus one edge for each paused cycle.
- pause in UP or DOWN: count, state and reps_done hold; busy stays 1. pause is ignored in IDLE and DONE.
- abort in UP or DOWN: state<=IDLE and count holds its value; done is not pulsed and reps_done holds. abort has priority over pause.
- start while busy or in DONE is ignored.
- Latched bounds are used for the whole sweep; changes to lo/hi/reps during a sweep have no effect.
- The counter never exceeds hi or goes below lo, so there is no wrap-around, including at hi=2^WIDTH-1 and lo=0.
- All outputs are registered except up and busy, which decode the registered state.

Optional Feature:
- Macro: UPDOWN_SWEEP_ERR_EN.
- Defined: adds port `err out 1`. An illegal start sets err=1 for one cycle; state stays IDLE. err is also cleared on the next legal start.
- Undefined: no err port; an illegal start is silently ignored. All other behaviour is identical.

Decomposition:
- Package updown_sweep_pkg holds:
  - the state enum typedef (IDLE/UP/DOWN/DONE);
  - default WIDTH and REPS_W localparams.
- One sub-module, sweep_step_counter: loadable WIDTH-bit counter with inputs load, load_val, en and up, and output count. The FSM lives in updown_sweep_ctrl.

Test Plan:
- Basic sweep: lo=2, hi=5, reps=1, start pulse → count 2,3,4,5,4,3,2 on successive edges; up=1 for the first three steps; done pulses exactly once, 6 edges after start; busy then drops.
- Repetition: lo=0, hi=3, reps=3 → three triangles 0→3→0; reps_done steps 1,2,3; done pulses after 18 edges.
- Pause: lo=2, hi=5, reps=1, pause held for 4 cycles when count=4 in UP → count frozen at 4; done is delayed by exactly 4 cycles.
- Abort mid-sweep: abort while count=4 in DOWN → next cycle busy=0, no done pulse, count stays 4. A new start then restarts from the new lo.
- Boundaries: lo=0, hi=15, reps=1 → no wrap; count peaks at 15; done 30 edges after start. A start pulse while busy is ignored.
- Illegal config and reset: lo=5, hi=5 → no sweep, plus err pulse when UPDOWN_SWEEP_ERR_EN is defined. Reset asserted mid-sweep → count=0, busy=0, done=0 on the next edge.
